// File: rtl/serial_sub_pkg.sv
// Shared FSM state encodings and legal WIDTH range for the bit-serial subtractor.
// Pure declarations; no timing or flow-control content.
// Used by the controller and its bench.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    // Counter must reach WIDTH without wrapping on the final RUN edge.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_subtractor_using_demux.sv
// 1-bit full subtractor built from a 3-to-8 demux of a constant 1 (select = {a,b,bin}).
// Latency: purely combinational.
// Backpressure: none; no flow control.
module full_subtractor_using_demux (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    // Only the demux lines that feed an output are decoded.
    logic line1, line2, line3, line4, line7;

    assign line1 = ~a & ~b &  bin;
    assign line2 = ~a &  b & ~bin;
    assign line3 = ~a &  b &  bin;
    assign line4 =  a & ~b & ~bin;
    assign line7 =  a &  b &  bin;

    assign diff = line1 | line2 | line4 | line7;
    assign bout = line1 | line2 | line3 | line7;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned A-B controller, LSB first, one bit per clock through a 1-bit cell.
// Latency: out_valid visible after accept edge + WIDTH; one op per WIDTH+2 cycles minimum.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, res_q, res_shift;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             cell_a, cell_b, cell_bin, cell_diff, cell_bout;
    logic             accept, last_bit;

    assign accept   = (state_q == IDLE) && in_valid;
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    full_subtractor_using_demux u_cell (
        .a    (cell_a),
        .b    (cell_b),
        .bin  (cell_bin),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_diff  = '0;
        out_borrow = 1'b0;
        // Cell is held at zero outside RUN so it stays quiet.
        cell_a    = 1'b0;
        cell_b    = 1'b0;
        cell_bin  = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                cell_a   = a_sh[0];
                cell_b   = b_sh[0];
                cell_bin = borrow_q;
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                out_valid  = 1'b1;
                out_diff   = res_q;
                out_borrow = borrow_q;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result fills from the MSB so the first (LSB) difference bit lands at bit 0 after WIDTH shifts.
    always_comb begin
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = cell_diff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sh     <= in_a;
            b_sh     <= in_b;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
        end else if (state_q == RUN) begin
            a_sh     <= a_sh >> 1;
            b_sh     <= b_sh >> 1;
            res_q    <= res_shift;
            borrow_q <= cell_bout;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

endmodule
